// File: rtl/mul_pkg.sv
// Shared constants and types for the 64-bit multiplier datapath.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 64;
  localparam int unsigned CPA_SEG_W = 16;

  typedef enum logic [1:0] {
    CPA_IDLE,
    CPA_ADD,
    CPA_DONE
  } cpa_state_t;

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG_W-bit adder with carry in/out; one segment of the sequential CPA.
module seg_adder #(
  parameter int unsigned SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/cpa_seg64.sv
// Sequential segmented carry-propagate adder: result = sum_i + (carry_i << 1), SEG_W bits per cycle.
// Optional CPA_COUT_EN adds a cout port carrying bit 64 of the addition.
module cpa_seg64
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned SEG_W = CPA_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] carry_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef CPA_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int unsigned NSEG  = WIDTH / SEG_W;
  localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NSEG - 1);

  if (WIDTH != 64) begin : g_bad_width
    $error("cpa_seg64: WIDTH must be 64");
  end
  if (!(SEG_W == 8 || SEG_W == 16 || SEG_W == 32 || SEG_W == 64)) begin : g_bad_seg_w
    $error("cpa_seg64: SEG_W must be 8, 16, 32 or 64");
  end

  cpa_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [SEG_W-1:0] seg_a, seg_b, seg_s;
  logic             seg_c;

  // The top carry bit has weight 2^64 after the shift and is dropped.
  logic unused_carry_msb;
  assign unused_carry_msb = carry_i[WIDTH-1];

  always_comb begin
    seg_a = a_q[idx_q*SEG_W +: SEG_W];
    seg_b = b_q[idx_q*SEG_W +: SEG_W];
  end

  seg_adder #(
    .SEG_W(SEG_W)
  ) u_seg_adder (
    .a   (seg_a),
    .b   (seg_b),
    .cin (carry_q),
    .s   (seg_s),
    .cout(seg_c)
  );

`ifdef CPA_COUT_EN
  logic cout_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CPA_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
`ifdef CPA_COUT_EN
      cout_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        CPA_IDLE: begin
          if (in_valid) begin
            a_q     <= sum_i;
            b_q     <= {carry_i[WIDTH-2:0], 1'b0};
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= CPA_ADD;
          end
        end
        CPA_ADD: begin
          result_q[idx_q*SEG_W +: SEG_W] <= seg_s;
          carry_q <= seg_c;
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            state_q <= CPA_DONE;
`ifdef CPA_COUT_EN
            cout_q  <= seg_c;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        CPA_DONE: begin
          if (out_ready) state_q <= CPA_IDLE;
        end
        default: state_q <= CPA_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == CPA_IDLE);
  assign out_valid = (state_q == CPA_DONE);
  assign result    = result_q;
`ifdef CPA_COUT_EN
  assign cout      = cout_q;
`endif

endmodule

// File: tb/tb_cpa_seg64.sv
// Self-checking bench for cpa_seg64: one instance per legal SEG_W (8/16/32/64).
module tb_cpa_seg64;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [63:0] sum_i     [NI];
  logic [63:0] carry_i   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [63:0] result    [NI];
  logic        cout      [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cpa_seg64 #(
      .WIDTH(64),
      .SEG_W(8 << g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .sum_i    (sum_i[g]),
      .carry_i  (carry_i[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result   (result[g])
`ifdef CPA_COUT_EN
      ,
      .cout     (cout[g])
`endif
    );
`ifndef CPA_COUT_EN
    assign cout[g] = 1'b0;
`endif
  end

  typedef struct {
    logic [63:0] sum;
    logic [63:0] carry;
    logic [63:0] exp_res;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [seg_w=%0d]: got %h, expected %h", name, 8 << k, act, exp);
    end
  endtask

  function automatic int nseg(input int k);
    return 64 / (8 << k);
  endfunction

  // Full reference: 65-bit sum of the sum row and the shifted carry row.
  function automatic logic [64:0] ref_add(input logic [63:0] s, input logic [63:0] c);
    logic [64:0] cs;
    cs = {c, 1'b0};
    cs[64] = 1'b0;
    return {1'b0, s} + cs;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; noise drives garbage in_valid/sum_i while busy.
  task automatic run_op(input int k, input logic [63:0] s, input logic [63:0] c, input bit noise,
                        output logic [63:0] res, output logic co, output int lat);
    sum_i[k]    = s;
    carry_i[k]  = c;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      if (noise) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        sum_i[k]    = {$urandom, $urandom};
        carry_i[k]  = {$urandom, $urandom};
      end
      tick();
      lat++;
    end
    in_valid[k] = 1'b0;
    res = result[k];
    co  = cout[k];
    if (noise) repeat ($urandom_range(0, 2)) tick();
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic check_op(input string name, input int k, input logic [63:0] s,
                          input logic [63:0] c, input bit noise);
    logic [63:0] res;
    logic        co;
    int          lat;
    logic [64:0] full;
    full = ref_add(s, c);
    chk({name, "_in_ready"}, k, 64'(in_ready[k]), 64'd1);
    run_op(k, s, c, noise, res, co, lat);
    chk({name, "_result"}, k, res, full[63:0]);
    chk({name, "_latency"}, k, 64'(lat), 64'(nseg(k)));
`ifdef CPA_COUT_EN
    chk({name, "_cout"}, k, 64'(co), 64'(full[64]));
`endif
  endtask

  initial begin
    logic [63:0] res, held;
    logic        co;
    int          lat;

    vecs[0] = '{64'h5, 64'h3, 64'hB, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b1};
    vecs[2] = '{64'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[4] = '{64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0, 1'b1};

    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      sum_i[k] = '0;
      carry_i[k] = '0;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NI; k++) begin
      chk("reset_in_ready", k, 64'(in_ready[k]), 64'd1);
      chk("reset_out_valid", k, 64'(out_valid[k]), 64'd0);
      chk("reset_result", k, result[k], 64'd0);
`ifdef CPA_COUT_EN
      chk("reset_cout", k, 64'(cout[k]), 64'd0);
`endif
    end

    // Directed vectors on every segment width.
    for (int k = 0; k < NI; k++) begin
      for (int v = 0; v < 6; v++) begin
        run_op(k, vecs[v].sum, vecs[v].carry, 1'b0, res, co, lat);
        chk($sformatf("vec%0d_result", v), k, res, vecs[v].exp_res);
        chk($sformatf("vec%0d_latency", v), k, 64'(lat), 64'(nseg(k)));
`ifdef CPA_COUT_EN
        chk($sformatf("vec%0d_cout", v), k, 64'(co), 64'(vecs[v].exp_cout));
`endif
      end
    end

    // Back-pressure in DONE: outputs hold, new inputs ignored.
    sum_i[1] = 64'h1111; carry_i[1] = 64'h2222; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 100) begin tick(); lat++; end
    held = result[1];
    chk("stall_first_result", 1, held, 64'h5555);
    for (int i = 0; i < 5; i++) begin
      in_valid[1] = 1'(i % 2 == 0);
      sum_i[1] = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      tick();
      chk("stall_out_valid", 1, 64'(out_valid[1]), 64'd1);
      chk("stall_in_ready", 1, 64'(in_ready[1]), 64'd0);
      chk("stall_result", 1, result[1], held);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("stall_release_in_ready", 1, 64'(in_ready[1]), 64'd1);
    tick();
    chk("stall_no_new_op", 1, 64'(in_ready[1]), 64'd1);
    chk("stall_no_out_valid", 1, 64'(out_valid[1]), 64'd0);

    // Reset in the middle of ADD discards the operation.
    sum_i[1] = 64'hFFFF_FFFF_FFFF_FFFF; carry_i[1] = 64'h1; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_in_ready", 1, 64'(in_ready[1]), 64'd1);
    chk("midreset_out_valid", 1, 64'(out_valid[1]), 64'd0);
    chk("midreset_result", 1, result[1], 64'd0);
`ifdef CPA_COUT_EN
    chk("midreset_cout", 1, 64'(cout[1]), 64'd0);
`endif
    check_op("after_reset", 1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);

    // Random traffic per segment width against the arithmetic reference.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 1)) tick();
        check_op("rand", k, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
